// File: rtl/sar_dac_sequencer_if.sv
// sar_dac_sequencer_if: configuration/DAC bus between the register block,
// the analog front end and the SAR sequencer.
// Optional macro SAR_DAC_CONT_EN adds the 'cont' (continuous conversion) input.
interface sar_dac_sequencer_if #(
  parameter int N        = 8,
  parameter int SETTLE_W = 4
);
  logic                start;
  logic                abort;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                comp_in;
`ifdef SAR_DAC_CONT_EN
  logic                cont;
`endif
  logic [N-1:0]        dac_code;
  logic                sample;
  logic                busy;
  logic                done;
  logic [N-1:0]        result;

`ifdef SAR_DAC_CONT_EN
  modport master (
    output start, abort, settle_cycles, comp_in, cont,
    input  dac_code, sample, busy, done, result
  );
  modport slave (
    input  start, abort, settle_cycles, comp_in, cont,
    output dac_code, sample, busy, done, result
  );
`else
  modport master (
    output start, abort, settle_cycles, comp_in,
    input  dac_code, sample, busy, done, result
  );
  modport slave (
    input  start, abort, settle_cycles, comp_in,
    output dac_code, sample, busy, done, result
  );
`endif
endinterface

// File: rtl/sar_dac_sequencer.sv
// sar_dac_sequencer: successive-approximation controller for the on-chip DAC
// and comparator. Track phase of S+1 cycles, then N binary-search trials, each
// preceded by S settle cycles, then a one-cycle DONE with the converted code.
// All outputs are registered: they are computed from the next-state values.
// Optional macro SAR_DAC_CONT_EN: 'cont' input restarts sampling from DONE.
module sar_dac_sequencer #(
  parameter int N        = 8,
  parameter int SETTLE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sar_dac_sequencer_if.slave bus
);

  localparam int IW = $clog2(N);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [2:0]          r_state;
  logic [IW-1:0]       r_idx;
  logic [N-1:0]        r_work;
  logic [SETTLE_W-1:0] r_s;
  logic [SETTLE_W-1:0] r_cnt;
  logic [N-1:0]        r_result;
  logic [N-1:0]        r_dac;
  logic                r_sample;
  logic                r_busy;
  logic                r_done;

  logic [2:0]          w_state_nxt;
  logic [IW-1:0]       w_idx_nxt;
  logic [N-1:0]        w_work_nxt;
  logic [SETTLE_W-1:0] w_s_nxt;
  logic [SETTLE_W-1:0] w_cnt_nxt;
  logic [N-1:0]        w_result_nxt;
  logic [N-1:0]        w_dac_nxt;
  logic [N-1:0]        w_bit;
  logic [N-1:0]        w_kept;

  // Current trial bit and the working value after the comparator decision
  always_comb begin
    w_bit  = ONE << r_idx;
    if (bus.comp_in) begin
      w_kept = r_work | w_bit;
    end else begin
      w_kept = r_work;
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_work_nxt   = r_work;
    w_s_nxt      = r_s;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_SAMPLE;
          w_s_nxt     = bus.settle_cycles;
          w_cnt_nxt   = bus.settle_cycles;
          w_work_nxt  = {N{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (r_cnt == {SETTLE_W{1'b0}}) begin
          w_idx_nxt = IW'(N - 1);
          if (r_s == {SETTLE_W{1'b0}}) begin
            w_state_nxt = ST_DECIDE;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = r_s - {{(SETTLE_W-1){1'b0}}, 1'b1};
          end
        end else begin
          w_cnt_nxt = r_cnt - {{(SETTLE_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SETTLE: begin
        if (r_cnt == {SETTLE_W{1'b0}}) begin
          w_state_nxt = ST_DECIDE;
        end else begin
          w_cnt_nxt = r_cnt - {{(SETTLE_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DECIDE: begin
        w_work_nxt = w_kept;
        if (r_idx == {IW{1'b0}}) begin
          w_state_nxt  = ST_DONE;
          w_result_nxt = w_kept;
        end else begin
          w_idx_nxt = r_idx - {{(IW-1){1'b0}}, 1'b1};
          if (r_s == {SETTLE_W{1'b0}}) begin
            w_state_nxt = ST_DECIDE;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = r_s - {{(SETTLE_W-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_DONE: begin
`ifdef SAR_DAC_CONT_EN
        if (bus.cont) begin
          w_state_nxt = ST_SAMPLE;
          w_s_nxt     = bus.settle_cycles;
          w_cnt_nxt   = bus.settle_cycles;
          w_work_nxt  = {N{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (bus.abort && (r_state != ST_IDLE)) begin
      w_state_nxt  = ST_IDLE;
      w_result_nxt = r_result;
    end else begin
      w_result_nxt = w_result_nxt;
    end
  end

  // DAC code that the next state presents
  always_comb begin
    case (w_state_nxt)
      ST_IDLE:              w_dac_nxt = w_result_nxt;
      ST_SAMPLE:            w_dac_nxt = {N{1'b0}};
      ST_SETTLE, ST_DECIDE: w_dac_nxt = w_work_nxt | (ONE << w_idx_nxt);
      ST_DONE:              w_dac_nxt = w_work_nxt;
      default:              w_dac_nxt = {N{1'b0}};
    endcase
  end

  // Sequencer state, counters and converted result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= {IW{1'b0}};
      r_work   <= {N{1'b0}};
      r_s      <= {SETTLE_W{1'b0}};
      r_cnt    <= {SETTLE_W{1'b0}};
      r_result <= {N{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_work   <= w_work_nxt;
      r_s      <= w_s_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Registered DAC/handshake outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dac    <= {N{1'b0}};
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_dac    <= w_dac_nxt;
      r_sample <= (w_state_nxt == ST_SAMPLE);
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.dac_code = r_dac;
  assign bus.sample   = r_sample;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;

endmodule

// File: tb/tb_sar_dac_sequencer.sv
// tb_sar_dac_sequencer: directed, table-driven bench for sar_dac_sequencer
// (N=8, SETTLE_W=4) with an ideal comparator model comp_in = (vin >= dac_code).
// Continuous-mode sequence is compiled in with SAR_DAC_CONT_EN.
module tb_sar_dac_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] vin;
  int         n_checks;
  int         n_fail;

  typedef struct {
    logic [7:0] vin;
    logic [3:0] s;
    logic [7:0] exp_res;
    int         exp_lat;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] seq_a5 [8];

  sar_dac_sequencer_if #(.N(8), .SETTLE_W(4)) bus ();

  sar_dac_sequencer #(.N(8), .SETTLE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.comp_in = (vin >= bus.dac_code);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One conversion from IDLE; checks latency, result, done width and IDLE code
  task automatic run_conv(input logic [7:0] v, input logic [3:0] s,
                          input logic [7:0] er, input int el, input string nm);
    int c;
    int busy_bad;
    vin = v;
    bus.settle_cycles = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 0;
    busy_bad = 0;
    while (bus.done !== 1'b1 && c < 400) begin
      if (bus.busy !== 1'b1) busy_bad++;
      @(negedge clk);
      c++;
    end
    chk({nm, " latency"}, c, el);
    chk({nm, " result"}, bus.result, er);
    chk({nm, " busy_gaps"}, busy_bad, 0);
    @(negedge clk);
    chk({nm, " done_width"}, bus.done, 1'b0);
    chk({nm, " busy_after"}, bus.busy, 1'b0);
    chk({nm, " idle_dac"}, bus.dac_code, er);
  endtask

  // Cycle-by-cycle trace of sample/dac_code for input 0xA5
  task automatic trace(input logic [3:0] s, input string nm);
    int per;
    logic [7:0] exp_dac;
    per = int'(s) + 1;
    vin = 8'hA5;
    bus.settle_cycles = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 9 * per; c++) begin
      if (c < per) exp_dac = 8'h00;
      else exp_dac = seq_a5[(c - per) / per];
      chk($sformatf("%s sample c%0d", nm, c), bus.sample, (c < per));
      chk($sformatf("%s dac c%0d", nm, c), bus.dac_code, exp_dac);
      chk($sformatf("%s busy c%0d", nm, c), bus.busy, 1'b1);
      @(negedge clk);
    end
    chk({nm, " done"}, bus.done, 1'b1);
    chk({nm, " result"}, bus.result, 8'hA5);
    @(negedge clk);
    chk({nm, " done_width"}, bus.done, 1'b0);
  endtask

  initial begin
    int n_done;
    int n_idle;
    int first_done;

    n_checks = 0;
    n_fail   = 0;
    seq_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vecs[0] = '{vin: 8'hA5, s: 4'd0,  exp_res: 8'hA5, exp_lat: 9};
    vecs[1] = '{vin: 8'hA5, s: 4'd3,  exp_res: 8'hA5, exp_lat: 36};
    vecs[2] = '{vin: 8'hFF, s: 4'd0,  exp_res: 8'hFF, exp_lat: 9};
    vecs[3] = '{vin: 8'h00, s: 4'd0,  exp_res: 8'h00, exp_lat: 9};
    vecs[4] = '{vin: 8'h3C, s: 4'd2,  exp_res: 8'h3C, exp_lat: 27};
    vecs[5] = '{vin: 8'h5A, s: 4'd1,  exp_res: 8'h5A, exp_lat: 18};
    vecs[6] = '{vin: 8'h01, s: 4'd15, exp_res: 8'h01, exp_lat: 144};
    vecs[7] = '{vin: 8'h80, s: 4'd0,  exp_res: 8'h80, exp_lat: 9};
    vecs[8] = '{vin: 8'h7F, s: 4'd4,  exp_res: 8'h7F, exp_lat: 45};

    rst_n = 1'b0;
    vin = 8'h00;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.settle_cycles = 4'd0;
`ifdef SAR_DAC_CONT_EN
    bus.cont = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset dac", bus.dac_code, 8'h00);
    chk("reset sample", bus.sample, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset result", bus.result, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    trace(4'd0, "trace_s0");
    trace(4'd3, "trace_s3");

    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].vin, vecs[i].s, vecs[i].exp_res, vecs[i].exp_lat,
               $sformatf("vec%0d", i));
    end

    // start held high: DONE -> IDLE -> accept, period 11 cycles at S=0
    vin = 8'hA5;
    bus.settle_cycles = 4'd0;
    bus.start = 1'b1;
    @(negedge clk);
    n_done = 0;
    n_idle = 0;
    for (int c = 0; c < 33; c++) begin
      if (bus.done === 1'b1) n_done++;
      if (bus.busy === 1'b0) n_idle++;
      if (c == 32) bus.start = 1'b0;
      @(negedge clk);
    end
    chk("held_start dones", n_done, 3);
    chk("held_start idle_cycles", n_idle, 3);

    // start pulses while busy/DONE and a settle change are ignored
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_done = 0;
    n_idle = 0;
    first_done = -1;
    for (int c = 0; c < 22; c++) begin
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (bus.busy === 1'b0) n_idle++;
      if (c == 2) bus.settle_cycles = 4'd5;
      if (c == 3 || c == 9) bus.start = 1'b1;
      if (c == 4 || c == 10) bus.start = 1'b0;
      @(negedge clk);
    end
    bus.settle_cycles = 4'd0;
    chk("busy_start dones", n_done, 1);
    chk("busy_start done_cycle", first_done, 9);
    chk("busy_start idle_cycles", n_idle, 12);

    // abort on the 4th DECIDE keeps the previous result
    run_conv(8'hA5, 4'd0, 8'hA5, 9, "pre_abort");
    vin = 8'h33;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort trial4 dac", bus.dac_code, 8'h30);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort busy", bus.busy, 1'b0);
    chk("abort sample", bus.sample, 1'b0);
    chk("abort done", bus.done, 1'b0);
    chk("abort result", bus.result, 8'hA5);
    chk("abort idle_dac", bus.dac_code, 8'hA5);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    chk("abort no_done", n_done, 0);

    // start and abort together in IDLE: start wins
    vin = 8'h5A;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort busy", bus.busy, 1'b1);
    chk("start_abort sample", bus.sample, 1'b1);
    repeat (9) @(negedge clk);
    chk("start_abort done", bus.done, 1'b1);
    chk("start_abort result", bus.result, 8'h5A);
    @(negedge clk);

    // asynchronous reset in the middle of SETTLE
    vin = 8'hA5;
    bus.settle_cycles = 4'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset settle_dac", bus.dac_code, 8'h80);
    rst_n = 1'b0;
    #1;
    chk("async_reset dac", bus.dac_code, 8'h00);
    chk("async_reset sample", bus.sample, 1'b0);
    chk("async_reset busy", bus.busy, 1'b0);
    chk("async_reset done", bus.done, 1'b0);
    chk("async_reset result", bus.result, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_conv(8'h5A, 4'd1, 8'h5A, 18, "post_reset");

`ifdef SAR_DAC_CONT_EN
    begin
      int c;
      int nd;
      int t [3];
      bus.cont = 1'b1;
      vin = 8'h3C;
      bus.settle_cycles = 4'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      c = 0;
      nd = 0;
      t = '{-1, -1, -1};
      while (nd < 3 && c < 100) begin
        if (bus.done === 1'b1) begin
          chk($sformatf("cont result%0d", nd), bus.result, 8'h3C);
          t[nd] = c;
          nd++;
        end
        if (nd == 3) bus.cont = 1'b0;
        else begin
          @(negedge clk);
          c++;
        end
      end
      chk("cont dones", nd, 3);
      chk("cont done0", t[0], 9);
      chk("cont done1", t[1], 19);
      chk("cont done2", t[2], 29);
      @(negedge clk);
      chk("cont stop busy", bus.busy, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
